// File: rtl/rpn_pkg.sv
// Shared types for the RPN sequencer: instruction classes, op codes, FSM states
// and the default instruction layout.
package rpn_pkg;

    localparam int DEF_DW        = 16;
    localparam int DEF_AW        = 10;
    localparam int STACK_MAX_DEF = 1000;

    typedef enum logic [1:0] {
        CLS_HALT = 2'b00,
        CLS_PUSH = 2'b01,
        CLS_OP   = 2'b10,
        CLS_ILL  = 2'b11
    } instr_cls_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_NEG = 2'd1,
        OP_ADD = 2'd2,
        OP_MUL = 2'd3
    } op_t;

    typedef enum logic [3:0] {
        IDLE,
        CLR_SET,
        CLR_STEP,
        FETCH,
        DECODE,
        SETUP,
        PULSE,
        HOLD,
        DONE,
        ERR
    } state_t;

    typedef struct packed {
        instr_cls_t          cls;
        logic [DEF_DW-1:0]   data;
    } instr_t;

    function automatic instr_t mk_push(input logic [DEF_DW-1:0] value);
        instr_t w;
        w.cls  = CLS_PUSH;
        w.data = value;
        return w;
    endfunction

    function automatic instr_t mk_op(input op_t code);
        instr_t w;
        w.cls  = CLS_OP;
        w.data = DEF_DW'(code);
        return w;
    endfunction

endpackage

// File: rtl/rpn_sequencer_if.sv
// Program-load bus, calculator strobes and run status of the RPN sequencer.
interface rpn_sequencer_if #(
    parameter int DW = 16,
    parameter int AW = 10
);
    logic          start;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [DW+1:0] prog_wdata;
    logic          calc_step;
    logic          calc_nrst;
    logic          calc_push;
    logic [DW-1:0] calc_d;
    logic [1:0]    calc_op;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] pc;
    logic [AW-1:0] depth;

    modport master (
        output start, prog_we, prog_addr, prog_wdata,
        input  calc_step, calc_nrst, calc_push, calc_d, calc_op,
        input  busy, done, error, pc, depth
    );

    modport slave (
        input  start, prog_we, prog_addr, prog_wdata,
        output calc_step, calc_nrst, calc_push, calc_d, calc_op,
        output busy, done, error, pc, depth
    );
endinterface

// File: rtl/rpn_prog_mem.sv
// 1R1W synchronous program RAM; read data appears one clock after re.
module rpn_prog_mem #(
    parameter int DW = 18,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        if (re)
            rdata <= mem[raddr];
    end
endmodule

// File: rtl/rpn_sequencer.sv
// Replays a stored RPN program into the stack calculator, one 5-clock step per
// instruction, halting on a shadow-depth stack violation.
module rpn_sequencer
    import rpn_pkg::*;
#(
    parameter int DW        = DEF_DW,
    parameter int AW        = DEF_AW,
    parameter int STACK_MAX = STACK_MAX_DEF
) (
    input logic           clk,
    input logic           rst,
    rpn_sequencer_if.slave bus
);
    localparam logic [AW-1:0] PC_LAST   = '1;
    localparam logic [AW-1:0] DEPTH_MAX = AW'(STACK_MAX);

    state_t        state, state_nx;
    logic [AW-1:0] pc, pc_nx;
    logic [AW-1:0] depth, depth_nx;
    logic          push, push_nx;
    logic [DW-1:0] d, d_nx;
    op_t           op, op_nx;
    logic          running;
    logic          rd_en;
    logic          wr_en;
    logic [DW+1:0] word;
    instr_cls_t    cls;
    op_t           word_op;

    assign running = !(state inside {IDLE, DONE, ERR});
    assign wr_en   = bus.prog_we && !running;
    assign cls     = instr_cls_t'(word[DW+1:DW]);
    assign word_op = op_t'(word[1:0]);

    rpn_prog_mem #(
        .DW(DW + 2),
        .AW(AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (bus.prog_addr),
        .wdata (bus.prog_wdata),
        .re    (rd_en),
        .raddr (pc),
        .rdata (word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= '0;
            depth <= '0;
            push  <= 1'b0;
            d     <= '0;
            op    <= OP_NOP;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            depth <= depth_nx;
            push  <= push_nx;
            d     <= d_nx;
            op    <= op_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        depth_nx = depth;
        push_nx  = push;
        d_nx     = d;
        op_nx    = op;
        rd_en    = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (bus.start) begin
                    state_nx = CLR_SET;
                    pc_nx    = '0;
                    depth_nx = '0;
                end
            end
            CLR_SET:  state_nx = CLR_STEP;
            CLR_STEP: state_nx = FETCH;
            FETCH: begin
                rd_en    = 1'b1;
                state_nx = DECODE;
            end
            DECODE: begin
                // Strobes are only ever loaded here, so they are stable through SETUP/PULSE/HOLD.
                case (cls)
                    CLS_HALT: state_nx = DONE;
                    CLS_ILL:  state_nx = ERR;
                    CLS_PUSH: begin
                        if (depth == DEPTH_MAX) begin
                            state_nx = ERR;
                        end else begin
                            push_nx  = 1'b1;
                            d_nx     = word[DW-1:0];
                            op_nx    = OP_NOP;
                            state_nx = SETUP;
                        end
                    end
                    default: begin
                        if ((word_op == OP_NEG && depth == '0) ||
                            ((word_op == OP_ADD || word_op == OP_MUL) && depth < AW'(2))) begin
                            state_nx = ERR;
                        end else begin
                            push_nx  = 1'b0;
                            d_nx     = '0;
                            op_nx    = word_op;
                            state_nx = SETUP;
                        end
                    end
                endcase
            end
            SETUP: state_nx = PULSE;
            PULSE: state_nx = HOLD;
            HOLD: begin
                if (push)
                    depth_nx = depth + AW'(1);
                else if (op == OP_ADD || op == OP_MUL)
                    depth_nx = depth - AW'(1);
                if (pc == PC_LAST) begin
                    state_nx = DONE;
                end else begin
                    pc_nx    = pc + AW'(1);
                    state_nx = FETCH;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.calc_step = (state == CLR_STEP) || (state == PULSE);
    assign bus.calc_nrst = !((state == CLR_SET) || (state == CLR_STEP));
    assign bus.calc_push = push;
    assign bus.calc_d    = d;
    assign bus.calc_op   = op;
    assign bus.busy      = running;
    assign bus.done      = (state == DONE);
    assign bus.error     = (state == ERR);
    assign bus.pc        = pc;
    assign bus.depth     = depth;
endmodule
